// File: rtl/binary_intermediate_collect.sv
// Reassembles per-block sign-bit slices into full binary token vectors and drains a frame in order.
// Optional macro BIN_COLLECT_ORDER_CHECK_EN: enforce block_sel == pass and flag mismatches on order_err.
module binary_intermediate_collect #(
    parameter int N_TOK   = 30,
    parameter int N_BLK   = 4,
    parameter int SLICE_W = 16,
    localparam int OUT_W  = N_BLK * SLICE_W,
    localparam int BLK_W  = (N_BLK > 1) ? $clog2(N_BLK) : 1,
    localparam int TOK_W  = (N_TOK > 1) ? $clog2(N_TOK) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SLICE_W-1:0] data_in,
    input  logic               data_in_valid,
    input  logic [BLK_W-1:0]   block_sel,
    output logic               in_ready,
    output logic [OUT_W-1:0]   data_out,
    output logic               data_out_valid,
    input  logic               data_out_ready,
    output logic               done,
    output logic               overflow,
    output logic               order_err
);

    typedef enum logic [0:0] {
        ST_COLLECT,
        ST_DRAIN
    } state_t;

    localparam logic [TOK_W-1:0] TOK_LAST  = TOK_W'(N_TOK - 1);
    localparam logic [BLK_W-1:0] PASS_LAST = BLK_W'(N_BLK - 1);

    state_t             state_reg, state_next;
    logic [TOK_W-1:0]   tok_reg, tok_next;
    logic [BLK_W-1:0]   pass_reg, pass_next;
    logic [TOK_W-1:0]   rd_reg, rd_next;
    logic               dout_valid_reg, dout_valid_next;
    logic               done_reg, done_next;
    logic               overflow_reg, overflow_next;

    logic               wr_en;
    logic               load_en;
    logic [TOK_W-1:0]   rd_addr;
    logic               order_bad;

`ifdef BIN_COLLECT_ORDER_CHECK_EN
    logic order_err_reg;

    assign order_bad = (block_sel != pass_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            order_err_reg <= 1'b0;
        end else if (state_reg == ST_COLLECT && data_in_valid && order_bad) begin
            order_err_reg <= 1'b1;
        end
    end

    assign order_err = order_err_reg;
`else
    assign order_bad = 1'b0;
    assign order_err = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        tok_next        = tok_reg;
        pass_next       = pass_reg;
        rd_next         = rd_reg;
        dout_valid_next = dout_valid_reg;
        done_next       = 1'b0;
        overflow_next   = overflow_reg;
        wr_en           = 1'b0;
        load_en         = 1'b0;
        rd_addr         = rd_reg;

        case (state_reg)
            ST_COLLECT: begin
                if (data_in_valid && !order_bad) begin
                    wr_en = 1'b1;
                    if (tok_reg == TOK_LAST) begin
                        tok_next = '0;
                        if (pass_reg == PASS_LAST) begin
                            pass_next  = '0;
                            rd_next    = '0;
                            state_next = ST_DRAIN;
                        end else begin
                            pass_next = pass_reg + BLK_W'(1);
                        end
                    end else begin
                        tok_next = tok_reg + TOK_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                // Upstream cannot be stalled, so anything arriving now is lost.
                if (data_in_valid) begin
                    overflow_next = 1'b1;
                end
                if (!dout_valid_reg) begin
                    // First cycle of the drain: prime the output register with token 0.
                    load_en         = 1'b1;
                    dout_valid_next = 1'b1;
                end else if (data_out_ready) begin
                    if (rd_reg == TOK_LAST) begin
                        dout_valid_next = 1'b0;
                        done_next       = 1'b1;
                        rd_next         = '0;
                        state_next      = ST_COLLECT;
                    end else begin
                        rd_next = rd_reg + TOK_W'(1);
                        rd_addr = rd_reg + TOK_W'(1);
                        load_en = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_COLLECT;
            tok_reg        <= '0;
            pass_reg       <= '0;
            rd_reg         <= '0;
            dout_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tok_reg        <= tok_next;
            pass_reg       <= pass_next;
            rd_reg         <= rd_next;
            dout_valid_reg <= dout_valid_next;
            done_reg       <= done_next;
            overflow_reg   <= overflow_next;
        end
    end

    // One narrow memory per block keeps each write a full-word RAM write.
    genvar gi;
    generate
        for (gi = 0; gi < N_BLK; gi++) begin : g_blk
            logic [SLICE_W-1:0] mem [N_TOK];
            logic [SLICE_W-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && block_sel == BLK_W'(gi)) begin
                    mem[tok_reg] <= data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (load_en) begin
                    rd_q <= mem[rd_addr];
                end
            end

            assign data_out[gi*SLICE_W +: SLICE_W] = rd_q;
        end
    endgenerate

    assign in_ready       = (state_reg == ST_COLLECT);
    assign data_out_valid = dout_valid_reg;
    assign done           = done_reg;
    assign overflow       = overflow_reg;

endmodule

// File: doc/binary_intermediate_collect.md
# binary_intermediate_collect

Downstream stage of the binarized intermediate (FFN) layer. Collects the 16-bit sign-bit slices produced per token and per weight block (`block_sel` pass) and reassembles them into full 64-bit binary token vectors in a 30-token frame buffer. Once the frame is complete, it streams the tokens out in order over a valid/ready interface to the next binarized layer.

## Interface
- `N_TOK`, default 30: tokens (time steps) per frame.
- `N_BLK`, default 4: weight blocks (passes) per frame; each pass supplies one slice of every token.
- `SLICE_W`, default 16: slice width; output width `OUT_W = N_BLK*SLICE_W` (64).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  SLICE_W  sign-bit slice from the intermediate stage.
- `data_in_valid`  in  1  slice qualifier; one slice per cycle max.
- `block_sel`  in  2  block index of the current slice (selects bit range `block_sel*SLICE_W +: SLICE_W`).
- `in_ready`  out  1  high in COLLECT; informational (upstream has no backpressure).
- `data_out`  out  OUT_W  reassembled token vector, registered.
- `data_out_valid`  out  1  `data_out` holds a token.
- `data_out_ready`  in  1  consumer accepts when `data_out_valid && data_out_ready` at a clock edge.
- `done`  out  1  one-cycle pulse after the last token of a frame is accepted.
- `overflow`  out  1  sticky; a slice arrived while not in COLLECT.
- `order_err`  out  1  sticky; slice `block_sel` mismatch (see Configuration).

## Operation
- Storage: `N_TOK` x `OUT_W` register array; no reset of contents required.
- Counters: `tok` (0..N_TOK-1), `pass` (0..N_BLK-1), `rd` (0..N_TOK-1).
- State COLLECT: on accepted slice, write `data_in` into `mem[tok][block_sel*SLICE_W +: SLICE_W]`; `tok` increments; when `tok == N_TOK-1` it wraps to 0 and `pass` increments. The accepted slice with `tok == N_TOK-1` and `pass == N_BLK-1` completes the frame; the next state is DRAIN, and `tok`, `pass`, and `rd` clear.
- State DRAIN: present `mem[rd]` with `data_out_valid = 1`. On handshake, `rd` increments and `data_out` loads the next token on the same edge (back-to-back, no bubble). On the handshake with `rd == N_TOK-1`:
  - `data_out_valid` goes to 0.
  - `done` is 1 for the next cycle.
  - The state returns to COLLECT.
- Stall: while `data_out_ready = 0`, `data_out` and `data_out_valid` are held stable.
- `data_in_valid` in DRAIN: slice dropped, memory untouched, `overflow` set; `overflow` is cleared only by `rst`.
- Reset, including mid-frame or mid-drain: state COLLECT, all counters 0, `data_out = 0`, `data_out_valid = 0`, `done = 0`, `overflow = 0`, `order_err = 0`, `in_ready = 1` (next cycle). The partial frame is discarded.

## Timing
- Write latency: a slice sampled at edge T is readable from `mem` after T.
- Frame-complete slice sampled at edge T: `data_out_valid = 1` with token 0 from edge T+1. This is a one-cycle load; `data_out` is registered from `mem[0]` at T+1, so valid is visible in cycle T+1..T+2.
- With `data_out_ready` held high, tokens 0..29 appear on 30 consecutive cycles. `done` is high the cycle after token 29's handshake, and `in_ready` is high in that same cycle.
- `in_ready` is decoded from the state register, so it has no combinational path from inputs.
- Frame throughput limit: `N_TOK*N_BLK` input cycles plus at least `N_TOK` + 1 output cycles.

## Configuration
- Macro: `BIN_COLLECT_ORDER_CHECK_EN`.
- Defined: an accepted slice must have `block_sel == pass`. On mismatch the slice is dropped (no write, no counter advance) and `order_err` is set (sticky until `rst`).
- Undefined: `block_sel` is used unchecked for the slice position, counters advance on every COLLECT slice, and `order_err` is tied 0.

## Test plan
- Nominal frame: 120 slices, pass b = token t and slice `16'h1000*b + t`, `ready = 1` throughout. Expected: 30 back-to-back outputs, token t = `{16'h3000+t, 16'h2000+t, 16'h1000+t, t}`, then a single `done` pulse, `overflow = 0`.
- Backpressure: same frame, `data_out_ready` toggled 1/0 every cycle. Expected: each token held unchanged during stall cycles, tokens in order 0..29, `done` once after the 30th handshake.
- Overflow: 3 slices driven in DRAIN with `data_in = 16'hFFFF`. Expected: `overflow = 1`, drained tokens unchanged.
- Order check (macro defined): slice with `block_sel = 2` during pass 0. Expected: `order_err = 1` and the slice is not written. With 120 correct slices also sent, the frame still completes. Macro undefined: `order_err` stays 0.
- Reset mid-drain: `rst` after token 10 is accepted. Expected: `data_out_valid = 0`, `done` never pulses, `in_ready = 1`. A following full frame drains from token 0 correctly.
- Back-to-back frames: second frame starts the cycle `done` is high. Expected: accepted, second frame output correct.
